multiplier_sequential_n_bit: RTL
================================

// Module: multiplier_sequential_n_bit
// PURPOSE
//   Parametrised sequential shift-add multiplier, successor to the 2-bit combinational unit.
//   Computes a WIDTH x WIDTH product in 2*WIDTH bits over WIDTH iteration cycles.
//   Selects signed (two's complement) or unsigned arithmetic per operation.
//   Uses a start/busy/done handshake. Sits in the arithmetic library as the area-lean multiply.
// PARAMETERS
//   WIDTH  8  operand width in bits; legal range 2..32; product width is 2*WIDTH
// PORTS
//   Clock_In               in   1        rising-edge clock
//   Reset_In               in   1        asynchronous, active-high reset
//   Start_In               in   1        request; sampled only in IDLE
//   Signed_In              in   1        1 = two's complement operands, 0 = unsigned; sampled with Start_In
//   Data_A_In              in   WIDTH    multiplicand; sampled with Start_In
//   Data_B_In              in   WIDTH    multiplier; sampled with Start_In
//   Busy_Out               out  1        high in CALC and DONE states
//   Done_Out               out  1        one-cycle pulse; result valid
//   Multiplied_Result_Out  out  2*WIDTH  product; held until next accepted Start
// BEHAVIOUR
//   Reset
//     - Asserting Reset_In at any time, including mid-operation, forces IDLE immediately.
//     - Busy_Out=0, Done_Out=0, Multiplied_Result_Out=0, internal registers cleared.
//     - An operation in flight is discarded; no Done pulse.
//   FSM: IDLE -> CALC -> DONE -> IDLE
//     - IDLE: at an edge with Start_In=1, latch operands and Signed_In, load counter=WIDTH, go to CALC.
//     - CALC: one iteration per clock.
//       - If multiplier LSB=1, add multiplicand magnitude into the upper accumulator half.
//       - Shift the accumulator right by 1; decrement the counter.
//       - Go to DONE when the counter reaches 0, i.e. after exactly WIDTH CALC cycles.
//     - DONE: Done_Out=1 for this one cycle only; Multiplied_Result_Out already valid; next state IDLE.
//   Latency
//     - Start accepted at edge k.
//     - Busy_Out high from edge k to edge k+WIDTH+1.
//     - Done_Out high between edges k+WIDTH and k+WIDTH+1.
//     - Earliest next accept at edge k+WIDTH+2 (Start_In may be held high for back-to-back operations).
//   Handshake
//     - Start_In is ignored while Busy_Out=1 (CALC or DONE). Operands are not re-sampled.
//   Arithmetic
//     - Signed_In=1: operate on |A| and |B|; negate the 2*WIDTH product if sign(A) XOR sign(B).
//     - The most-negative operand (-2^(WIDTH-1)) magnitude fits in WIDTH bits unsigned; no overflow.
//     - Signed_In=0: plain unsigned product.
//     - Accumulator is WIDTH+1 bits wide at the adder so the carry is not lost.
//     - Product is always exact; no truncation or saturation.
//   Output holding
//     - Multiplied_Result_Out updates only on entry to DONE.
//     - It holds through IDLE and the next CALC until the following DONE.
// TESTING
//   1. WIDTH=8, unsigned 255*255 -> Done one cycle after edge k+8; result 16'hFE01; Busy low after.
//   2. WIDTH=8, signed 8'h80*8'h80 (-128*-128) -> 16'h4000; signed 8'hFF*8'h05 -> 16'hFFFB (-5).
//   3. WIDTH=8, unsigned 8'hFF*8'h05 -> 16'h04FB; A=0 or B=0 in either mode -> 16'h0000.
//   4. Start_In pulsed during CALC with new operands -> ignored; first result delivered unchanged;
//      exactly one Done pulse.
//   5. Reset_In asserted at CALC cycle 3 -> outputs 0 immediately; no Done;
//      a fresh Start afterwards computes correctly.
//   6. WIDTH=2, exhaustive 16 pairs x both modes, Start held high -> each result matches reference a*b;
//      back-to-back Done spacing is WIDTH+2 cycles.

Source files
------------

// File: rtl/multiplier_sequential_n_bit.sv
// Sequential shift-add WIDTH x WIDTH multiplier with signed/unsigned select.
// Start/Busy/Done handshake; one shift-add iteration per clock in CALC.
module multiplier_sequential_n_bit #(
    parameter int unsigned WIDTH = 8
) (
    input  logic                 Clock_In,
    input  logic                 Reset_In,
    input  logic                 Start_In,
    input  logic                 Signed_In,
    input  logic [WIDTH-1:0]     Data_A_In,
    input  logic [WIDTH-1:0]     Data_B_In,
    output logic                 Busy_Out,
    output logic                 Done_Out,
    output logic [2*WIDTH-1:0]   Multiplied_Result_Out
);

    localparam int unsigned CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        CALC,
        DONE
    } state_t;

    state_t               state_q, state_d;
    logic [CW-1:0]        cnt_q, cnt_d;
    logic [WIDTH-1:0]     mcand_q, mcand_d;
    logic [2*WIDTH-1:0]   acc_q, acc_d;
    logic [2*WIDTH-1:0]   result_q, result_d;
    logic                 neg_q, neg_d;

    logic [WIDTH-1:0]     mag_a, mag_b;
    logic [WIDTH:0]       sum;
    logic [2*WIDTH-1:0]   acc_shift;

    // Operands are multiplied as magnitudes; the sign is reapplied on the full product.
    always_comb begin
        mag_a     = (Signed_In && Data_A_In[WIDTH-1]) ? -Data_A_In : Data_A_In;
        mag_b     = (Signed_In && Data_B_In[WIDTH-1]) ? -Data_B_In : Data_B_In;
        sum       = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + (acc_q[0] ? {1'b0, mcand_q} : '0);
        acc_shift = {sum, acc_q[WIDTH-1:1]};
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        mcand_d  = mcand_q;
        acc_d    = acc_q;
        result_d = result_q;
        neg_d    = neg_q;
        unique case (state_q)
            IDLE: begin
                if (Start_In) begin
                    mcand_d = mag_a;
                    acc_d   = {{WIDTH{1'b0}}, mag_b};
                    neg_d   = Signed_In & (Data_A_In[WIDTH-1] ^ Data_B_In[WIDTH-1]);
                    cnt_d   = CW'(WIDTH);
                    state_d = CALC;
                end
            end
            CALC: begin
                acc_d = acc_shift;
                cnt_d = cnt_q - CW'(1);
                if (cnt_q == CW'(1)) begin
                    result_d = neg_q ? -acc_shift : acc_shift;
                    state_d  = DONE;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge Clock_In or posedge Reset_In) begin
        if (Reset_In) begin
            state_q  <= IDLE;
            cnt_q    <= '0;
            mcand_q  <= '0;
            acc_q    <= '0;
            result_q <= '0;
            neg_q    <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            mcand_q  <= mcand_d;
            acc_q    <= acc_d;
            result_q <= result_d;
            neg_q    <= neg_d;
        end
    end

    assign Busy_Out              = (state_q != IDLE);
    assign Done_Out              = (state_q == DONE);
    assign Multiplied_Result_Out = result_q;

endmodule
